// File: rtl/uart_tx_cfg.sv
// UART transmitter with an input FIFO and per-frame configuration.
// The data width, parity, stop bits and bit period are latched when each frame starts.
module uart_tx_cfg #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [DIV_WIDTH-1:0]          cfg_div,
    input  logic [3:0]                    cfg_data_bits,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    input  logic [DATA_BITS-1:0]          s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          tx_done
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]        level_q, level_d;
    logic                 s_ready_q;

    logic [2:0]           state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [3:0]           bit_q, bit_d;
    logic [3:0]           nbits_q, nbits_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_bit_q, par_bit_d;
    logic                 par_en_q, par_en_d;
    logic                 stop2_q, stop2_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 push, pop, bit_end;
    logic [3:0]           nbits_eff;
    logic [DIV_WIDTH-1:0] div_eff;
    logic [DATA_BITS-1:0] mask, head_masked;

    assign push    = s_valid && s_ready_q;
    assign bit_end = (cnt_q == div_q - DIV_WIDTH'(1));
    assign div_eff = (cfg_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : cfg_div;

    // Configuration as it would be latched by a frame starting this cycle
    always_comb begin
        nbits_eff = cfg_data_bits;
        if (cfg_data_bits < 4'd5) begin
            nbits_eff = 4'd5;
        end else if (cfg_data_bits > 4'(DATA_BITS)) begin
            nbits_eff = 4'(DATA_BITS);
        end
        mask = '0;
        for (int i = 0; i < int'(DATA_BITS); i++) begin
            mask[i] = (i < int'(nbits_eff));
        end
        head_masked = mem_q[rd_ptr_q] & mask;
    end

    // Next-state logic for the frame sequencer
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        bit_d     = bit_q;
        nbits_d   = nbits_q;
        shreg_d   = shreg_q;
        par_bit_d = par_bit_q;
        par_en_d  = par_en_q;
        stop2_d   = stop2_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pop       = 1'b0;

        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + DIV_WIDTH'(1);
        end

        case (state_q)
            S_IDLE: begin
                tx_d  = 1'b1;
                cnt_d = '0;
                pop   = (level_q != '0);
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    tx_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == nbits_q - 4'd1) begin
                        bit_d = '0;
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        tx_d    = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (!stop2_q || bit_q[0]) begin
                        done_d = 1'b1;
                        if (level_q != '0) begin
                            pop = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // Frame start: take the FIFO head and freeze the configuration
        if (pop) begin
            state_d   = S_START;
            cnt_d     = '0;
            bit_d     = '0;
            tx_d      = 1'b0;
            busy_d    = 1'b1;
            div_d     = div_eff;
            nbits_d   = nbits_eff;
            shreg_d   = head_masked;
            par_bit_d = (^head_masked) ^ (cfg_parity == 2'b10);
            par_en_d  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
            stop2_d   = cfg_stop2;
        end

        level_d = level_q + LW'(push) - LW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            s_ready_q <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            div_q     <= DIV_WIDTH'(2);
            bit_q     <= '0;
            nbits_q   <= 4'd5;
            shreg_q   <= '0;
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q   <= level_d;
            s_ready_q <= (level_d < LW'(FIFO_DEPTH));
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            nbits_q   <= nbits_d;
            shreg_q   <= shreg_d;
            par_bit_q <= par_bit_d;
            par_en_q  <= par_en_d;
            stop2_q   <= stop2_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign fifo_level = level_q;
    assign tx         = tx_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;

endmodule
